// File: rtl/bayes_axi_master.sv
// bayes_axi_master: single-burst AXI4 initiator streaming classifier vectors to and from memory
module bayes_axi_master #(
  parameter int C_AXI_ID_WIDTH   = 2,
  parameter int C_AXI_DATA_WIDTH = 32,
  parameter int C_AXI_ADDR_WIDTH = 32,
  parameter int C_AXI_ID         = 0
) (
  input  logic                          M_AXI_ACLK,
  input  logic                          M_AXI_ARESET,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic                          cmd_write,
  input  logic [C_AXI_ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [7:0]                    cmd_len,
  input  logic [C_AXI_DATA_WIDTH-1:0]   wr_data,
  input  logic                          wr_valid,
  output logic                          wr_ready,
  output logic [C_AXI_DATA_WIDTH-1:0]   rd_data,
  output logic                          rd_valid,
  input  logic                          rd_ready,
  output logic                          rd_last,
  output logic                          done,
  output logic                          err,
  output logic [C_AXI_ID_WIDTH-1:0]     M_AXI_AWID,
  output logic [C_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic [7:0]                    M_AXI_AWLEN,
  output logic [2:0]                    M_AXI_AWSIZE,
  output logic [1:0]                    M_AXI_AWBURST,
  output logic                          M_AXI_AWLOCK,
  output logic [3:0]                    M_AXI_AWCACHE,
  output logic [2:0]                    M_AXI_AWPROT,
  output logic [3:0]                    M_AXI_AWQOS,
  output logic                          M_AXI_AWVALID,
  input  logic                          M_AXI_AWREADY,
  output logic [C_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [C_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  output logic                          M_AXI_WLAST,
  output logic                          M_AXI_WVALID,
  input  logic                          M_AXI_WREADY,
  input  logic [C_AXI_ID_WIDTH-1:0]     M_AXI_BID,
  input  logic [1:0]                    M_AXI_BRESP,
  input  logic                          M_AXI_BVALID,
  output logic                          M_AXI_BREADY,
  output logic [C_AXI_ID_WIDTH-1:0]     M_AXI_ARID,
  output logic [C_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic [7:0]                    M_AXI_ARLEN,
  output logic [2:0]                    M_AXI_ARSIZE,
  output logic [1:0]                    M_AXI_ARBURST,
  output logic                          M_AXI_ARLOCK,
  output logic [3:0]                    M_AXI_ARCACHE,
  output logic [2:0]                    M_AXI_ARPROT,
  output logic [3:0]                    M_AXI_ARQOS,
  output logic                          M_AXI_ARVALID,
  input  logic                          M_AXI_ARREADY,
  input  logic [C_AXI_ID_WIDTH-1:0]     M_AXI_RID,
  input  logic [C_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
  input  logic [1:0]                    M_AXI_RRESP,
  input  logic                          M_AXI_RLAST,
  input  logic                          M_AXI_RVALID,
  output logic                          M_AXI_RREADY
);
  localparam int LB = (C_AXI_DATA_WIDTH == 64) ? 3 : 2;
  typedef enum logic [2:0] {IDLE, CHECK, RD_ADDR, RD_DATA, WR_ADDR, WR_DATA, WR_RESP, DONE} state_t;
  state_t state_q, state_d;
  logic write_q, write_d, err_q, err_d;
  logic [C_AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [7:0] len_q, len_d, cnt_q, cnt_d;
  logic last, bad, unused_ids;
  logic [13:0] span;
  assign unused_ids = ^{M_AXI_BID, M_AXI_RID};
  assign last = cnt_q == len_q;
  assign span = {2'b00, addr_q[11:0]} + ((14'(len_q) + 14'd1) << LB);
  assign bad = (|addr_q[LB-1:0]) || (span > 14'd4096);
  assign cmd_ready = state_q == IDLE;
  assign M_AXI_AWID = C_AXI_ID_WIDTH'(C_AXI_ID);
  assign M_AXI_AWADDR = addr_q;
  assign M_AXI_AWLEN = len_q;
  assign M_AXI_AWSIZE = 3'(LB);
  assign M_AXI_AWBURST = 2'b01;
  assign M_AXI_AWLOCK = 1'b0;
  assign M_AXI_AWCACHE = 4'b0011;
  assign M_AXI_AWPROT = 3'b000;
  assign M_AXI_AWQOS = 4'b0000;
  assign M_AXI_AWVALID = state_q == WR_ADDR;
  assign M_AXI_ARID = C_AXI_ID_WIDTH'(C_AXI_ID);
  assign M_AXI_ARADDR = addr_q;
  assign M_AXI_ARLEN = len_q;
  assign M_AXI_ARSIZE = 3'(LB);
  assign M_AXI_ARBURST = 2'b01;
  assign M_AXI_ARLOCK = 1'b0;
  assign M_AXI_ARCACHE = 4'b0011;
  assign M_AXI_ARPROT = 3'b000;
  assign M_AXI_ARQOS = 4'b0000;
  assign M_AXI_ARVALID = state_q == RD_ADDR;
  assign M_AXI_WDATA = wr_data;
  assign M_AXI_WSTRB = '1;
  assign M_AXI_WLAST = last;
  assign M_AXI_WVALID = (state_q == WR_DATA) && wr_valid;
  assign wr_ready = (state_q == WR_DATA) && M_AXI_WREADY;
  assign M_AXI_BREADY = state_q == WR_RESP;
  assign rd_data = M_AXI_RDATA;
  assign rd_valid = (state_q == RD_DATA) && M_AXI_RVALID;
  assign rd_last = (state_q == RD_DATA) && last;
  assign M_AXI_RREADY = (state_q == RD_DATA) && rd_ready;
  assign done = state_q == DONE;
  assign err = done && err_q;
  // burst sequencing: the beat counter, not RLAST, decides when a burst ends
  always_comb begin
    state_d = state_q;
    write_d = write_q;
    addr_d = addr_q;
    len_d = len_q;
    cnt_d = cnt_q;
    err_d = err_q;
    case (state_q)
      IDLE: if (cmd_valid) begin
        write_d = cmd_write;
        addr_d = cmd_addr;
        len_d = cmd_len;
        cnt_d = '0;
        err_d = 1'b0;
        state_d = CHECK;
      end
      CHECK: begin
        err_d = bad;
        state_d = bad ? DONE : write_q ? WR_ADDR : RD_ADDR;
      end
      WR_ADDR: state_d = M_AXI_AWREADY ? WR_DATA : WR_ADDR;
      WR_DATA: if (wr_valid && M_AXI_WREADY) begin
        cnt_d = last ? 8'd0 : cnt_q + 8'd1;
        state_d = last ? WR_RESP : WR_DATA;
      end
      WR_RESP: if (M_AXI_BVALID) begin
        err_d = err_q | (M_AXI_BRESP != 2'b00);
        state_d = DONE;
      end
      RD_ADDR: state_d = M_AXI_ARREADY ? RD_DATA : RD_ADDR;
      RD_DATA: if (M_AXI_RVALID && rd_ready) begin
        err_d = err_q | (M_AXI_RRESP != 2'b00) | (M_AXI_RLAST != last);
        cnt_d = last ? 8'd0 : cnt_q + 8'd1;
        state_d = last ? DONE : RD_DATA;
      end
      default: state_d = IDLE;
    endcase
  end
  // state and command registers; reset aborts any burst in flight
  always_ff @(posedge M_AXI_ACLK) begin
    if (M_AXI_ARESET) begin
      state_q <= IDLE;
      write_q <= 1'b0;
      addr_q <= '0;
      len_q <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      write_q <= write_d;
      addr_q <= addr_d;
      len_q <= len_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
endmodule

// File: tb/tb_bayes_axi_master.sv
// tb_bayes_axi_master: randomized scoreboard bench for the AXI burst master
module tb_bayes_axi_master;
  localparam int IW = 2, DW = 32, AW = 32, NB = DW / 8;
  typedef struct packed {logic [DW-1:0] d; logic l;} beat_t;
  typedef struct packed {logic w; logic [AW-1:0] a; logic [7:0] n;} ax_t;
  typedef struct packed {logic e; int lat;} done_t;
  logic clk = 0, rst = 1;
  logic cmd_valid = 0, cmd_ready, cmd_write = 0;
  logic [AW-1:0] cmd_addr = '0;
  logic [7:0] cmd_len = '0;
  logic [DW-1:0] wr_data = '0, rd_data;
  logic wr_valid = 0, wr_ready, rd_valid, rd_ready = 0, rd_last, done, err;
  logic [IW-1:0] awid, arid, bid = '0, rid = '0;
  logic [AW-1:0] awaddr, araddr;
  logic [7:0] awlen, arlen;
  logic [2:0] awsize, arsize, awprot, arprot;
  logic [1:0] awburst, arburst, bresp = '0, rresp = '0;
  logic awlock, arlock, awvalid, arvalid, awready = 0, arready = 0;
  logic [3:0] awcache, arcache, awqos, arqos;
  logic [DW-1:0] wdata, rdata = '0;
  logic [NB-1:0] wstrb;
  logic wlast, wvalid, wready = 0, bvalid = 0, bready, rlast = 0, rvalid = 0, rready;
  int checks = 0, errors = 0, cyc = 0, acc = 0, n_done = 0;
  bit sb_on = 1, slow = 0, w_ok = 0;
  int rd_mode = 0, r_err_beat = -1, r_last_beat = 0;
  logic [1:0] b_plan = 2'b00;
  beat_t exp_r[$], exp_w[$];
  ax_t exp_ax[$];
  done_t exp_d[$];
  logic [DW-1:0] wq[$];

  bayes_axi_master #(.C_AXI_ID_WIDTH(IW), .C_AXI_DATA_WIDTH(DW), .C_AXI_ADDR_WIDTH(AW), .C_AXI_ID(0)) dut (
    .M_AXI_ACLK(clk), .M_AXI_ARESET(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_last(rd_last), .done(done), .err(err),
    .M_AXI_AWID(awid), .M_AXI_AWADDR(awaddr), .M_AXI_AWLEN(awlen), .M_AXI_AWSIZE(awsize), .M_AXI_AWBURST(awburst),
    .M_AXI_AWLOCK(awlock), .M_AXI_AWCACHE(awcache), .M_AXI_AWPROT(awprot), .M_AXI_AWQOS(awqos),
    .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
    .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WLAST(wlast), .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
    .M_AXI_BID(bid), .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
    .M_AXI_ARID(arid), .M_AXI_ARADDR(araddr), .M_AXI_ARLEN(arlen), .M_AXI_ARSIZE(arsize), .M_AXI_ARBURST(arburst),
    .M_AXI_ARLOCK(arlock), .M_AXI_ARCACHE(arcache), .M_AXI_ARPROT(arprot), .M_AXI_ARQOS(arqos),
    .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
    .M_AXI_RID(rid), .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RLAST(rlast), .M_AXI_RVALID(rvalid),
    .M_AXI_RREADY(rready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] mem(input logic [AW-1:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_00A0;
  endfunction

  task automatic chk(input bit ok, input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // write-data source feeding the planned beats with optional gaps
  initial begin
    bit h;
    forever begin
      @(negedge clk);
      h = wr_valid && wr_ready;
      @(posedge clk); #1;
      if (h && wq.size() > 0) void'(wq.pop_front());
      wr_valid = wq.size() > 0 && (!slow || $urandom_range(0, 1) == 1);
      wr_data = wq.size() > 0 ? wq[0] : '0;
    end
  end

  // read-data consumer back-pressure
  initial forever begin
    @(posedge clk); #1;
    rd_ready = rd_mode == 0 ? 1'b1 : rd_mode == 1 ? ~rd_ready : 1'($urandom_range(0, 1));
  end

  // write-side slave
  initial begin
    bit rs, hw, hb, bpend;
    bpend = 0;
    forever begin
      @(negedge clk);
      rs = rst; hw = wvalid && wready && wlast; hb = bvalid && bready;
      @(posedge clk); #1;
      if (rs) begin
        awready = 0; wready = 0; bvalid = 0; bpend = 0;
      end else begin
        awready = slow ? 1'($urandom_range(0, 1)) : 1'b1;
        wready = slow ? 1'($urandom_range(0, 1)) : 1'b1;
        if (hw) bpend = 1;
        if (hb) bvalid = 0;
        if (bpend && (!slow || $urandom_range(0, 2) == 0)) begin
          bvalid = 1; bresp = b_plan; bpend = 0;
        end
      end
    end
  end

  // read-side slave returning memory contents with planned faults
  initial begin
    bit rs, har, hr, act;
    int ri, rn;
    logic [AW-1:0] ra, ca;
    logic [7:0] cl;
    act = 0; ri = 0; rn = 0; ra = '0;
    forever begin
      @(negedge clk);
      rs = rst; har = arvalid && arready; hr = rvalid && rready; ca = araddr; cl = arlen;
      @(posedge clk); #1;
      if (rs) begin
        arready = 0; rvalid = 0; act = 0;
      end else begin
        if (har) begin ra = ca; rn = int'(cl); ri = 0; act = 1; end
        if (hr) begin ri++; rvalid = 0; if (ri > rn) act = 0; end
        arready = slow ? 1'($urandom_range(0, 1)) : 1'b1;
        if (act && !rvalid && (!slow || $urandom_range(0, 1) == 1)) begin
          rvalid = 1;
          rdata = mem(ra + AW'(ri * NB));
          rresp = ri == r_err_beat ? 2'b10 : 2'b00;
          rlast = ri == r_last_beat;
        end
      end
    end
  end

  // monitor: pops expectations whenever the DUT presents a transfer
  initial begin
    beat_t b;
    ax_t x;
    done_t dn;
    bit dp;
    dp = 0;
    forever begin
      @(negedge clk);
      if (!rst && sb_on) begin
        if (wvalid && wready) begin
          chk(w_ok, "w_before_aw", 64'(w_ok), 64'(1));
          if (exp_w.size() == 0) chk(0, "w_unexpected", 64'(wdata), 64'(0));
          else begin
            b = exp_w.pop_front();
            chk({wdata, wlast, wstrb} == {b.d, b.l, {NB{1'b1}}}, "w_beat", 64'({wdata, wlast}), 64'({b.d, b.l}));
          end
        end
        if (arvalid || awvalid) begin
          if (exp_ax.size() == 0) chk(0, "ax_unexpected", 64'(awvalid ? awaddr : araddr), 64'(0));
          else begin
            x = exp_ax[0];
            chk({awvalid, arvalid, awvalid ? awaddr : araddr, awvalid ? awlen : arlen} == {x.w, !x.w, x.a, x.n},
                "ax_req", 64'({awvalid, arvalid, awvalid ? awaddr : araddr, awvalid ? awlen : arlen}),
                64'({x.w, !x.w, x.a, x.n}));
            chk((awvalid ? {awid, awsize, awburst, awlock, awcache, awprot, awqos}
                         : {arid, arsize, arburst, arlock, arcache, arprot, arqos}) ==
                {2'd0, 3'd2, 2'b01, 1'b0, 4'b0011, 3'd0, 4'd0}, "ax_attr",
                64'(awvalid ? {awid, awsize, awburst, awlock, awcache, awprot, awqos}
                            : {arid, arsize, arburst, arlock, arcache, arprot, arqos}),
                64'({2'd0, 3'd2, 2'b01, 1'b0, 4'b0011, 3'd0, 4'd0}));
            if ((awvalid && awready) || (arvalid && arready)) begin
              void'(exp_ax.pop_front());
              w_ok = awvalid;
            end
          end
        end
        if (rd_valid) chk(rready == rd_ready, "rready_mirror", 64'(rready), 64'(rd_ready));
        if (rd_valid && rd_ready) begin
          if (exp_r.size() == 0) chk(0, "r_unexpected", 64'(rd_data), 64'(0));
          else begin
            b = exp_r.pop_front();
            chk({rd_data, rd_last} == {b.d, b.l}, "r_beat", 64'({rd_data, rd_last}), 64'({b.d, b.l}));
          end
        end
        if (done) begin
          chk(!dp, "done_pulse", 64'(dp), 64'(0));
          if (exp_d.size() == 0) chk(0, "done_unexpected", 64'(err), 64'(0));
          else begin
            dn = exp_d.pop_front();
            chk(err == dn.e, "done_err", 64'(err), 64'(dn.e));
            if (dn.lat >= 0) chk(cyc - acc == dn.lat, "latency", 64'(cyc - acc), 64'(dn.lat));
          end
          chk(exp_r.size() + exp_w.size() == 0, "beats_left", 64'(exp_r.size() + exp_w.size()), 64'(0));
          w_ok = 0;
          n_done++;
        end
        dp = done;
      end else begin
        dp = 0;
        w_ok = 0;
      end
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1; cmd_valid = 0;
    @(posedge clk); #1;
    rst = 0;
    exp_r.delete(); exp_w.delete(); exp_ax.delete(); exp_d.delete(); wq.delete();
  endtask

  // reference model: expected bus requests, beats and completion status of one command
  task automatic run(input bit w, input logic [AW-1:0] a, input int n, input bit berr, input int rerr, input int rlb);
    bit bad, e;
    logic [DW-1:0] d;
    int t, nd;
    bad = (a % NB) != 0 || int'(a[11:0]) + (n + 1) * NB > 4096;
    e = bad || (w ? berr : (rerr >= 0 && rerr <= n) || rlb != n);
    b_plan = berr ? 2'b10 : 2'b00;
    r_err_beat = rerr;
    r_last_beat = rlb;
    if (!bad) begin
      exp_ax.push_back('{w: w, a: a, n: 8'(n)});
      for (int i = 0; i <= n; i++) begin
        d = w ? DW'($urandom) : mem(a + AW'(i * NB));
        if (w) begin
          exp_w.push_back('{d: d, l: i == n});
          wq.push_back(d);
        end else exp_r.push_back('{d: d, l: i == n});
      end
    end
    exp_d.push_back('{e: e, lat: bad ? 2 : w ? (slow ? -1 : n + 5) : (slow || rd_mode != 0 ? -1 : n + 4)});
    @(posedge clk); #1;
    cmd_valid = 1; cmd_write = w; cmd_addr = a; cmd_len = 8'(n);
    t = 0;
    @(negedge clk);
    while (!cmd_ready && t < 100) begin @(negedge clk); t++; end
    chk(cmd_ready, "cmd_ready", 64'(cmd_ready), 64'(1));
    acc = cyc;
    nd = n_done;
    @(posedge clk); #1;
    cmd_valid = 0;
    t = 0;
    while (n_done == nd && t < 3000) begin @(negedge clk); t++; end
    if (n_done == nd) begin
      chk(0, "done_timeout", 64'(t), 64'(0));
      do_reset();
    end
    repeat ($urandom_range(0, 3)) @(posedge clk);
  endtask

  initial begin
    int k, t;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk({cmd_ready, awvalid, arvalid, wvalid, bready, rready, rd_valid, done, err} == 9'b1_0000_0000, "reset_state",
        64'({cmd_ready, awvalid, arvalid, wvalid, bready, rready, rd_valid, done, err}), 64'(9'b1_0000_0000));
    @(posedge clk); #1;
    rst = 0;
    slow = 0; rd_mode = 0;
    run(0, 32'h1000, 3, 0, -1, 3);
    slow = 1;
    run(1, 32'h2000, 1, 0, -1, 1);
    slow = 0;
    run(1, 32'h2100, 0, 0, -1, 0);
    rd_mode = 1;
    run(0, 32'h3000, 7, 0, -1, 7);
    rd_mode = 0;
    run(0, 32'h0FF8, 3, 0, -1, 3);
    run(1, 32'h1002, 3, 0, -1, 3);
    run(0, 32'h0FF0, 3, 0, -1, 3);
    run(1, 32'h4000, 2, 1, -1, 2);
    run(0, 32'h5000, 3, 0, 1, 3);
    run(0, 32'h5100, 3, 0, -1, 1);
    sb_on = 0;
    r_err_beat = -1; r_last_beat = 3;
    @(posedge clk); #1;
    cmd_valid = 1; cmd_write = 0; cmd_addr = 32'h6000; cmd_len = 8'd3;
    @(posedge clk); #1;
    cmd_valid = 0;
    k = 0; t = 0;
    while (k < 2 && t < 50) begin
      @(negedge clk); t++;
      if (rd_valid && rd_ready) k++;
    end
    chk(k == 2, "mid_burst_reach", 64'(k), 64'(2));
    do_reset();
    @(negedge clk);
    chk({rready, arvalid, cmd_ready, done} == 4'b0010, "mid_burst_reset",
        64'({rready, arvalid, cmd_ready, done}), 64'(4'b0010));
    sb_on = 1;
    run(0, 32'h6000, 3, 0, -1, 3);
    for (int i = 0; i < 40; i++) begin
      bit w;
      logic [AW-1:0] a;
      int n;
      w = 1'($urandom_range(0, 1));
      n = $urandom_range(0, 3) == 0 ? int'($urandom_range(0, 63)) : int'($urandom_range(0, 7));
      a = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 3) == 0) a[11:0] = 12'(4096 - 4 * $urandom_range(1, 40));
      if ($urandom_range(0, 7) == 0) a[1:0] = 2'($urandom_range(1, 3));
      slow = 1'($urandom_range(0, 1));
      rd_mode = int'($urandom_range(0, 2));
      run(w, a, n, $urandom_range(0, 7) == 0,
          $urandom_range(0, 7) == 0 ? int'($urandom_range(0, n)) : -1,
          $urandom_range(0, 9) == 0 ? int'($urandom_range(0, n)) : n);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
